// File: rtl/clear_pulse_driver.sv
// ---------------------------------------------------------------------------
// clear_pulse_driver
//
// Transmit side of the single-bit "clear" interface consumed by the 2-bit
// state FSM.  On an accepted start it emits N one-cycle pulses on a_out.
// Each pulse is preceded by an idle gap of P+1 cycles, and the train ends
// with a one-cycle done strobe.
//
// Timing, with start accepted at edge 0:
//   - the first a_out pulse is the cycle starting at edge P+1
//   - pulses repeat every P+3 cycles
//   - done is the cycle starting at edge N*(P+3)
//
// Parameters
//   PERIOD_W  width of the gap-length field and the gap counter
//   COUNT_W   width of the pulse-count field and the remaining counter
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     command strobe, only looked at while idle
//   period    gap length P, captured when start is accepted
//   count     pulse count N, captured when start is accepted
//   state_in  state reported back by the consumer FSM
//   a_out     clear pulse, high for exactly one cycle per pulse
//   busy      high while a train is in progress (GAP/PULSE/CHECK)
//   done      one-cycle completion strobe
//   err_cnt   saturating count of CHECK cycles where state_in != 2'b00
//             (only when STATE_CHECK_EN is defined)
//
// Build option
//   STATE_CHECK_EN : enables the consumer-state check and the err_cnt port.
//                    Without it, state_in is accepted but ignored.
// ---------------------------------------------------------------------------
module clear_pulse_driver #(
  parameter int PERIOD_W = 8,
  parameter int COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  count,
  input  logic [1:0]          state_in,
  output logic                a_out,
  output logic                busy,
  output logic                done
`ifdef STATE_CHECK_EN
  ,
  output logic [7:0]          err_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_PULSE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [PERIOD_W-1:0] P_ZERO = {PERIOD_W{1'b0}};
  localparam logic [PERIOD_W-1:0] P_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0]  C_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0]  C_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_s;
  logic [PERIOD_W-1:0]  period_r;
  logic [PERIOD_W-1:0]  period_s;
  logic [PERIOD_W-1:0]  gap_cnt_r;
  logic [PERIOD_W-1:0]  gap_cnt_s;
  logic [COUNT_W-1:0]   remaining_r;
  logic [COUNT_W-1:0]   remaining_s;
  logic                 err_clr_s;
  logic                 err_inc_s;

  // Next-state and datapath update for the pulse-train sequencer
  always_comb begin
    state_s     = state_r;
    period_s    = period_r;
    gap_cnt_s   = gap_cnt_r;
    remaining_s = remaining_r;
    err_clr_s   = 1'b0;
    err_inc_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          // Every accepted start begins a fresh error tally, even an empty train
          err_clr_s = 1'b1;
          if (count != C_ZERO) begin
            period_s    = period;
            gap_cnt_s   = period;
            remaining_s = count;
            state_s     = ST_GAP;
          end else begin
            // Empty train: straight to completion, busy never rises
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_GAP: begin
        // The zero-test comes before the decrement, so the gap lasts P+1 cycles
        if (gap_cnt_r == P_ZERO) begin
          state_s = ST_PULSE;
        end else begin
          gap_cnt_s = gap_cnt_r - P_ONE;
          state_s   = ST_GAP;
        end
      end

      ST_PULSE: begin
        state_s = ST_CHECK;
      end

      ST_CHECK: begin
        // remaining is at least 1 here, so the decrement never wraps
        remaining_s = remaining_r - C_ONE;
`ifdef STATE_CHECK_EN
        // The consumer has had the PULSE-ending edge to drop back to state 0
        if (state_in != 2'b00) begin
          err_inc_s = 1'b1;
        end else begin
          err_inc_s = 1'b0;
        end
`endif
        if (remaining_s == C_ZERO) begin
          state_s = ST_DONE;
        end else begin
          gap_cnt_s = period_r;
          state_s   = ST_GAP;
        end
      end

      ST_DONE: begin
        // Any start seen here is dropped, not queued
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, latched operands, and output flops decoded from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      period_r    <= P_ZERO;
      gap_cnt_r   <= P_ZERO;
      remaining_r <= C_ZERO;
      a_out       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_s;
      period_r    <= period_s;
      gap_cnt_r   <= gap_cnt_s;
      remaining_r <= remaining_s;
      a_out       <= (state_s == ST_PULSE);
      busy        <= (state_s == ST_GAP) || (state_s == ST_PULSE) ||
                     (state_s == ST_CHECK);
      done        <= (state_s == ST_DONE);
    end
  end

`ifdef STATE_CHECK_EN
  // Saturating mismatch counter; keeps its value after DONE until the next start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'h00;
    end else if (err_clr_s) begin
      err_cnt <= 8'h00;
    end else if (err_inc_s && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end else begin
      err_cnt <= err_cnt;
    end
  end

  // Every bit of the clear and increment strobes feeds the counter in this build
  logic unused_chk_s;
  assign unused_chk_s = 1'b0;
`else
  // state_in stays on the port list for a stable interface but is not consumed
  logic unused_chk_s;
  assign unused_chk_s = ^{state_in, err_clr_s, err_inc_s};
`endif

endmodule
